// File: rtl/adsr_vca.sv
// ADSR envelope generator with an 8x9-bit VCA on the mixer output.
// The envelope advances only on sample_tick. audio_out is audio_in scaled by
// the envelope's upper byte plus one, with one clk of latency.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   sample_tick     one-clk envelope advance strobe
//   gate            note on/off, level-sensitive
//   attack_rate, decay_rate, release_rate   step selects, step=(rate+1)<<RATE_SHIFT
//   sustain_level   sustain target, upper byte of envelope
//   audio_in        unsigned mixer sample
//   audio_out       enveloped sample (registered)
//   env_level       env[15:8]
//   env_state       IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active          high when env_state != IDLE
module adsr_vca #(
   parameter int unsigned RATE_SHIFT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_tick,
   input  logic       gate,
   input  logic [7:0] attack_rate,
   input  logic [7:0] decay_rate,
   input  logic [7:0] sustain_level,
   input  logic [7:0] release_rate,
   input  logic [7:0] audio_in,
   output logic [7:0] audio_out,
   output logic [7:0] env_level,
   output logic [2:0] env_state,
   output logic       active
);

   localparam int unsigned ENV_W  = 16;
   localparam int unsigned STEP_W = 17;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t             state, state_nx;
   logic [ENV_W-1:0]   env, env_nx;
   logic               gate_q;
   logic               rise;
   logic [STEP_W-1:0]  s_a, s_d, s_r, s_lvl, env_w;
   logic [STEP_W-1:0]  prod;

   // All envelope arithmetic is held at 17 bits so no sum or compare can wrap.
   assign s_a   = (STEP_W'(attack_rate)  + STEP_W'(1)) << RATE_SHIFT;
   assign s_d   = (STEP_W'(decay_rate)   + STEP_W'(1)) << RATE_SHIFT;
   assign s_r   = (STEP_W'(release_rate) + STEP_W'(1)) << RATE_SHIFT;
   assign s_lvl = STEP_W'({sustain_level, 8'h00});
   assign env_w = STEP_W'(env);
   assign rise  = gate & ~gate_q;

   // State, envelope and gate history registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         env    <= '0;
         gate_q <= 1'b0;
         active <= 1'b0;
      end else begin
         state  <= state_nx;
         env    <= env_nx;
         gate_q <= gate;
         active <= (state_nx != IDLE);
      end
   end

   // Next-state / next-envelope: retrigger, then note-off, then tick update
   always_comb begin
      state_nx = state;
      env_nx   = env;
      if (rise) begin
         state_nx = ATTACK;
      end else if (!gate && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
         state_nx = RELEASE;
      end else if (sample_tick) begin
         unique case (state)
            IDLE: env_nx = '0;
            ATTACK: begin
               // env + sA >= 0xFFFF is the overflow-free form of env >= 0xFFFF - sA
               if (env_w + s_a >= STEP_W'(16'hFFFF)) begin
                  env_nx   = 16'hFFFF;
                  state_nx = DECAY;
               end else begin
                  env_nx = ENV_W'(env_w + s_a);
               end
            end
            DECAY: begin
               // Also snaps env up to S when sustain was raised above it
               if (env_w <= s_lvl + s_d) begin
                  env_nx   = ENV_W'(s_lvl);
                  state_nx = SUSTAIN;
               end else begin
                  env_nx = ENV_W'(env_w - s_d);
               end
            end
            SUSTAIN: env_nx = ENV_W'(s_lvl);
            RELEASE: begin
               if (env_w <= s_r) begin
                  env_nx   = '0;
                  state_nx = IDLE;
               end else begin
                  env_nx = ENV_W'(env_w - s_r);
               end
            end
            default: begin
               env_nx   = '0;
               state_nx = IDLE;
            end
         endcase
      end
   end

   // VCA: gain is env[15:8]+1 so full scale passes audio_in unchanged
   assign prod = STEP_W'(audio_in) * (STEP_W'(env[15:8]) + STEP_W'(1));

   always_ff @(posedge clk) begin
      if (rst) audio_out <= '0;
      else     audio_out <= prod[15:8];
   end

   assign env_level = env[15:8];
   assign env_state = state;

endmodule

// File: tb/tb_adsr_vca.sv
// Self-checking bench for adsr_vca with RATE_SHIFT=8.
// Fixed rates: attack 0x3F (sA=0x4000), decay 0x0F (sD=0x1000),
// release 0x1F (sR=0x2000). Expected values are hand-derived per cycle.
module tb_adsr_vca;

   typedef struct {
      logic       rst;
      logic       tick;
      logic       gate;
      logic [7:0] sus;
      logic [7:0] ain;
      logic [7:0] lvl;
      logic [2:0] st;
      logic       chk_aud;
      logic [7:0] aud;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_tick = 1'b0;
   logic       gate = 1'b0;
   logic [7:0] attack_rate = 8'h3F;
   logic [7:0] decay_rate = 8'h0F;
   logic [7:0] sustain_level = 8'h80;
   logic [7:0] release_rate = 8'h1F;
   logic [7:0] audio_in = 8'h00;
   logic [7:0] audio_out;
   logic [7:0] env_level;
   logic [2:0] env_state;
   logic       active;

   int n_chk = 0;
   int n_fail = 0;

   vec_t tbl[31];
   vec_t sb[$];

   adsr_vca #(.RATE_SHIFT(8)) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .gate(gate),
      .attack_rate(attack_rate), .decay_rate(decay_rate),
      .sustain_level(sustain_level), .release_rate(release_rate),
      .audio_in(audio_in), .audio_out(audio_out), .env_level(env_level),
      .env_state(env_state), .active(active)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic r, input logic t, input logic g,
                               input logic [7:0] s, input logic [7:0] a,
                               input logic [7:0] l, input logic [2:0] st,
                               input logic c, input logic [7:0] au);
      vec_t v;
      v.rst = r; v.tick = t; v.gate = g; v.sus = s; v.ain = a;
      v.lvl = l; v.st = st; v.chk_aud = c; v.aud = au;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got 0x%02h expected 0x%02h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle, queue its expectation, then compare after the edge
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      rst = v.rst; sample_tick = v.tick; gate = v.gate;
      sustain_level = v.sus; audio_in = v.ain;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("env_level", idx, env_level, e.lvl);
      chk("env_state", idx, 8'(env_state), 8'(e.st));
      chk("active", idx, 8'(active), 8'(e.st != 3'd0));
      if (e.chk_aud) chk("audio_out", idx, audio_out, e.aud);
   endtask

   task automatic step(input logic t, input logic g, input logic [7:0] s,
                       input logic [7:0] l, input logic [2:0] st, input int idx);
      apply(mk(1'b0, t, g, s, 8'h00, l, st, 1'b0, 8'h00), idx);
   endtask

   initial begin
      logic [7:0] atk_lvl[4];
      logic [7:0] dec_lvl[8];
      int k;
      atk_lvl = '{8'h40, 8'h80, 8'hC0, 8'hFF};
      dec_lvl = '{8'hEF, 8'hDF, 8'hCF, 8'hBF, 8'hAF, 8'h9F, 8'h8F, 8'h80};

      // reset with gate held high, then attack
      tbl[0]  = mk(1, 1, 1, 8'h80, 8'hFF, 8'h00, 3'd0, 1, 8'h00);
      tbl[1]  = mk(1, 1, 1, 8'h80, 8'hFF, 8'h00, 3'd0, 1, 8'h00);
      tbl[2]  = mk(1, 1, 1, 8'h80, 8'hFF, 8'h00, 3'd0, 1, 8'h00);
      tbl[3]  = mk(0, 1, 1, 8'h80, 8'hFF, 8'h00, 3'd1, 1, 8'h00);
      tbl[4]  = mk(0, 1, 1, 8'h80, 8'hFF, 8'h40, 3'd1, 1, 8'h00);
      tbl[5]  = mk(0, 1, 1, 8'h80, 8'hFF, 8'h80, 3'd1, 1, 8'h40);
      tbl[6]  = mk(0, 1, 1, 8'h80, 8'hFF, 8'hC0, 3'd1, 1, 8'h80);
      tbl[7]  = mk(0, 1, 1, 8'h80, 8'hFF, 8'hFF, 3'd2, 1, 8'hC0);
      // decay to sustain 0x80 on the 8th tick
      tbl[8]  = mk(0, 1, 1, 8'h80, 8'hC0, 8'hEF, 3'd2, 1, 8'hC0);
      tbl[9]  = mk(0, 1, 1, 8'h80, 8'hC0, 8'hDF, 3'd2, 1, 8'hB4);
      tbl[10] = mk(0, 1, 1, 8'h80, 8'hC0, 8'hCF, 3'd2, 0, 8'h00);
      tbl[11] = mk(0, 1, 1, 8'h80, 8'hC0, 8'hBF, 3'd2, 0, 8'h00);
      tbl[12] = mk(0, 1, 1, 8'h80, 8'hC0, 8'hAF, 3'd2, 0, 8'h00);
      tbl[13] = mk(0, 1, 1, 8'h80, 8'hC0, 8'h9F, 3'd2, 0, 8'h00);
      tbl[14] = mk(0, 1, 1, 8'h80, 8'hC0, 8'h8F, 3'd2, 0, 8'h00);
      tbl[15] = mk(0, 1, 1, 8'h80, 8'hC0, 8'h80, 3'd3, 1, 8'h6C);
      tbl[16] = mk(0, 1, 1, 8'h80, 8'hC0, 8'h80, 3'd3, 1, 8'h60);
      // release from 0x8000
      tbl[17] = mk(0, 1, 0, 8'h80, 8'hC0, 8'h80, 3'd4, 1, 8'h60);
      tbl[18] = mk(0, 1, 0, 8'h80, 8'hC0, 8'h60, 3'd4, 0, 8'h00);
      tbl[19] = mk(0, 1, 0, 8'h80, 8'hC0, 8'h40, 3'd4, 0, 8'h00);
      tbl[20] = mk(0, 1, 0, 8'h80, 8'hC0, 8'h20, 3'd4, 0, 8'h00);
      tbl[21] = mk(0, 1, 0, 8'h80, 8'hC0, 8'h00, 3'd0, 0, 8'h00);
      tbl[22] = mk(0, 1, 0, 8'h80, 8'h77, 8'h00, 3'd0, 1, 8'h00);
      // retrigger during release keeps level
      tbl[23] = mk(0, 1, 1, 8'h80, 8'h00, 8'h00, 3'd1, 0, 8'h00);
      tbl[24] = mk(0, 1, 1, 8'h80, 8'h00, 8'h40, 3'd1, 0, 8'h00);
      tbl[25] = mk(0, 1, 0, 8'h80, 8'h00, 8'h40, 3'd4, 0, 8'h00);
      tbl[26] = mk(0, 1, 1, 8'h80, 8'h00, 8'h40, 3'd1, 0, 8'h00);
      tbl[27] = mk(0, 1, 1, 8'h80, 8'h00, 8'h80, 3'd1, 0, 8'h00);
      tbl[28] = mk(0, 1, 0, 8'h80, 8'hFF, 8'h80, 3'd4, 0, 8'h00);
      // reset mid-note aborts without release
      tbl[29] = mk(1, 1, 0, 8'h80, 8'hFF, 8'h00, 3'd0, 1, 8'h00);
      tbl[30] = mk(0, 1, 0, 8'h80, 8'hFF, 8'h00, 3'd0, 1, 8'h00);

      for (int i = 0; i < 31; i++) apply(tbl[i], i);
      k = 100;

      // no ticks: state follows gate, env frozen at 0
      step(0, 1, 8'h80, 8'h00, 3'd1, k++);
      step(0, 0, 8'h80, 8'h00, 3'd4, k++);
      for (int i = 0; i < 20; i++) step(0, 0, 8'h80, 8'h00, 3'd4, k++);
      step(1, 0, 8'h80, 8'h00, 3'd0, k++);

      // climb to sustain, then track a sustain change
      step(1, 1, 8'h80, 8'h00, 3'd1, k++);
      for (int i = 0; i < 4; i++) step(1, 1, 8'h80, atk_lvl[i], (i == 3) ? 3'd2 : 3'd1, k++);
      for (int i = 0; i < 8; i++) step(1, 1, 8'h80, dec_lvl[i], (i == 7) ? 3'd3 : 3'd2, k++);
      step(0, 1, 8'h40, 8'h80, 3'd3, k++);
      step(1, 1, 8'h40, 8'h40, 3'd3, k++);

      // note-off without ticks holds a nonzero envelope
      for (int i = 0; i < 20; i++) step(0, 0, 8'h40, 8'h40, 3'd4, k++);
      step(1, 0, 8'h40, 8'h20, 3'd4, k++);
      step(1, 0, 8'h40, 8'h00, 3'd0, k++);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/adsr_vca.md
Name: adsr_vca

Overview:
- Per-note ADSR envelope generator and voltage-controlled amplifier (VCA).
- Sits directly downstream of the 6-channel waveform mixer. It consumes the mixer's 8-bit unsigned mixed output and scales it by a 16-bit envelope.
- The envelope advances once per sample_tick.
- audio_out feeds the output DAC/PWM stage.

Parameters:
- RATE_SHIFT, 0: left shift applied to every rate step, giving step = (rate+1) << RATE_SHIFT. Legal range 0..8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sample_tick  input  1  one-clk pulse; envelope advances only on cycles where it is 1
- gate  input  1  note on (1) / note off (0), level-sensitive
- attack_rate  input  8  attack step select
- decay_rate  input  8  decay step select
- sustain_level  input  8  sustain level, upper byte of envelope
- release_rate  input  8  release step select
- audio_in  input  8  unsigned mixer output
- audio_out  output  8  enveloped audio, registered
- env_level  output  8  env[15:8]
- env_state  output  3  current state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- active  output  1  high when env_state != IDLE

Behaviour:

Reset:
- rst=1 at a clk edge sets state=IDLE, env=0, gate_q=0, audio_out=0.
- Reset mid-note aborts the note immediately. No release is performed.
- gate held high across reset release is seen as a rising edge on the first cycle after reset, so ATTACK starts.

Internal signals and arithmetic:
- env is a 16-bit unsigned register. gate_q is gate delayed one clk.
- rise = gate & ~gate_q.
- Steps are 17-bit: sA=(attack_rate+1)<<RATE_SHIFT; sD, sR likewise from decay_rate and release_rate.
- S = {sustain_level, 8'h00}.
- All compares and sums are done at 17 bits. No wrap-around is permitted.

Priority within each cycle, highest first:
1. rise: go to ATTACK from any state. env is held this cycle (retrigger keeps current level, no reset to 0).
2. gate==0 while in ATTACK, DECAY or SUSTAIN: go to RELEASE. env is held this cycle.
3. Otherwise, if sample_tick=1, apply the per-state update below.
4. Otherwise, state and env hold.

Per-state update on sample_tick:
- IDLE: env=0.
- ATTACK:
  - if env >= 0xFFFF - sA: env=0xFFFF, go to DECAY;
  - else env += sA.
- DECAY:
  - if env <= S + sD: env=S, go to SUSTAIN;
  - else env -= sD.
  - Note: if sustain was raised above env, this snaps env up to S.
- SUSTAIN: env=S. sustain_level changes are tracked on every tick.
- RELEASE:
  - if env <= sR: env=0, go to IDLE;
  - else env -= sR.

VCA:
- audio_out <= (audio_in * (env[15:8] + 1)) >> 8, computed as 8x9-bit with a 17-bit product.
- Updated every clk, giving 1-clk latency from env/audio_in to audio_out.
- env[15:8]=0xFF passes audio_in unchanged. env[15:8]=0 gives 0.

Outputs:
- env_level and env_state reflect the registers directly, with no extra latency.

Test Plan:
All scenarios use RATE_SHIFT=8 and sample_tick=1 every clk unless noted.

1. Reset: rst=1, gate=1, audio_in=0xFF for 3 clk -> audio_out=0x00, env_level=0x00, env_state=0, active=0. First clk after rst=0 -> env_state=1.
2. Attack, attack_rate=0x3F (sA=0x4000): gate rises ->
   - entry cycle: env_level holds 0x00;
   - next ticks: env_level 0x40, 0x80, 0xC0, then 0xFF with env_state=2 (DECAY).
3. Decay, decay_rate=0x0F, sustain_level=0x80, starting from env=0xFFFF:
   - SUSTAIN (env=0x8000) is reached on the 8th tick;
   - audio_in=0xC0 -> audio_out=0x60 one clk later.
4. Release, release_rate=0x1F, gate=0 in SUSTAIN at env=0x8000:
   - 1 cycle RELEASE entry with env held;
   - then env_level 0x60, 0x40, 0x20, 0x00, with env_state=0 and active=0 on the 4th tick.
5. Retrigger: gate rises during RELEASE at env=0x4000 -> env_state=1 and env holds 0x4000 that cycle. Next tick env=0x8000 with attack_rate=0x3F.
6. Tick gating: sample_tick=0 throughout:
   - gate rise -> env_state=1, env_level stays 0;
   - gate fall -> env_state=4;
   - env unchanged for 20 clk.
   - Sustain tracking: in SUSTAIN, change sustain_level 0x80->0x40 -> env_level=0x40 after next tick.
